fb_rect_fill: RTL and testbench
===============================

FB_RECT_FILL -- requirements
Module: fb_rect_fill

Interface
REQ-001 CLK  input  1  system clock, same 50 MHz domain as the framebuffer write port.
REQ-002 RST  input  1  asynchronous, active-high reset.
REQ-003 START  input  1  command strobe; sampled on rising CLK edges, acted on only in IDLE.
REQ-004 X0  input  6  first column of the rectangle, inclusive.
REQ-005 Y0  input  5  first row of the rectangle, inclusive.
REQ-006 X1  input  6  last column of the rectangle, inclusive.
REQ-007 Y1  input  5  last row of the rectangle, inclusive.
REQ-008 COLOR  input  8  fill value, RGB 3:3:2.
REQ-009 BUSY  output  1  high while fill writes are in progress.
REQ-010 DONE  output  1  one-cycle pulse when a fill completes.
REQ-011 ERR  output  1  one-cycle pulse when a command is rejected.
REQ-012 WA  output  11  framebuffer write address, formed as {row[4:0], col[5:0]}.
REQ-013 WD  output  8  framebuffer write data.
REQ-014 WE  output  1  framebuffer write enable.

Function
REQ-015 FSM states: IDLE, FILL, FIN, REJ; one-hot or binary encoding is free.
REQ-016 In IDLE with START=1, the block shall latch X0, Y0, X1, Y1 and COLOR on that edge.
- Invalid command (X0>X1 or Y0>Y1): go to REJ, no writes.
- Valid command: go to FILL with col=X0 and row=Y0.
REQ-017 START shall be ignored in FILL, FIN and REJ; the command inputs may change freely after the accepting edge.
REQ-018 In FILL:
- WE=1, BUSY=1, WA={row, col}, WD=latched COLOR.
- Exactly one write per cycle.
- First write appears in the cycle after the accepting edge.
REQ-019 Scan order shall be raster: col increments first; at col=X1, col reloads X0 and row increments.
- At col=X1 and row=Y1, the next state is FIN.
REQ-020 A fill shall perform exactly (X1-X0+1)*(Y1-Y0+1) writes, with no duplicate or skipped addresses.
REQ-021 FIN lasts one cycle: DONE=1, BUSY=0, WE=0; then IDLE.
REQ-022 REJ lasts one cycle: ERR=1, BUSY=0, WE=0; then IDLE.
REQ-023 Outside FILL: WE=0, WA=0, WD=0.
REQ-024 Row and column counters shall not wrap within a command, because X1 and Y1 bound them.
REQ-025 A single-pixel command (X0=X1, Y0=Y1) shall issue one write, then DONE on the following cycle.
REQ-026 START held high continuously shall start a new command in each IDLE cycle, i.e. back-to-back commands separated by FIN and IDLE.

Reset
REQ-027 RST=1 shall force, asynchronously: state IDLE; BUSY, DONE, ERR and WE at 0; WA, WD and all latched registers at 0.
REQ-028 RST asserted mid-FILL shall drop WE immediately with no DONE; the aborted fill leaves the already-written pixels unchanged.
REQ-029 The first START is accepted on the first rising edge after RST deasserts.

Configuration
REQ-030 With macro FB_RECT_CLIP_EN defined, the visible area is 40 columns x 30 rows, and on acceptance:
- X1 is clamped to 39 and Y1 is clamped to 29.
- X0>39 or Y0>29 is rejected via REJ.
- The X0>X1 / Y0>Y1 check is applied after clamping.
REQ-031 Without FB_RECT_CLIP_EN, coordinates are used unmodified over the full 64x32 address space; the only rejection is X0>X1 or Y0>Y1.

Structure
REQ-032 Shared package fb_pkg shall hold:
- FB_COLS=40, FB_ROWS=30.
- Column width 6, row width 5, address width 11, color width 8.
- The FSM state enum type.
REQ-033 No sub-module; the counters and FSM live in fb_rect_fill.

Verification
REQ-034 Fill (2,3)-(4,4) with COLOR=8'hE0: 6 writes on consecutive cycles at WA 0x0C2, 0x0C3, 0x0C4, 0x102, 0x103, 0x104; DONE 1 cycle after the last write; BUSY high for exactly 6 cycles.
REQ-035 X0=5, X1=4: ERR pulses 1 cycle after START, WE never asserts, DONE stays 0.
REQ-036 With FB_RECT_CLIP_EN, (38,28)-(63,31): 4 writes at 0x726, 0x727, 0x766, 0x767; a separate command with X0=40 raises ERR.
REQ-037 Without FB_RECT_CLIP_EN, (0,0)-(63,31) with 8'hFF: 2048 writes covering WA 0x000-0x7FF in order, then DONE.
REQ-038 RST pulsed after the 3rd write of a 4x4 fill: WE=0 in the same cycle, no DONE; a new single-pixel command (0,0) then writes 0x000 once.
REQ-039 START re-pulsed during FILL with different coordinates: ignored, and the original write sequence completes unchanged.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer rectangle-fill block.
// Contents: visible area size, coordinate/address/color widths and the
// fill controller FSM state type.
package fb_pkg;

  localparam int unsigned FB_COLS = 40;
  localparam int unsigned FB_ROWS = 30;

  localparam int unsigned COL_W   = 6;
  localparam int unsigned ROW_W   = 5;
  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned COLOR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FIN  = 2'd2,
    REJ  = 2'd3
  } fb_state_t;

endpackage

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: writes COLOR to every pixel of an inclusive
// rectangle (X0,Y0)-(X1,Y1) in raster order, one framebuffer write per cycle.
//
// Ports:
//   CLK, RST        clock; asynchronous active-high reset
//   START           command strobe, honoured only while idle
//   X0, Y0, X1, Y1  inclusive rectangle corners (6-bit columns, 5-bit rows)
//   COLOR           fill value, RGB 3:3:2
//   BUSY            high while fill writes are issued
//   DONE            one-cycle pulse after the last write
//   ERR             one-cycle pulse when a command is rejected
//   WA, WD, WE      framebuffer write port, WA = {row, col}
//
// Build option: define FB_RECT_CLIP_EN to clip commands to the 40x30
// visible area (X1/Y1 clamped, out-of-area X0/Y0 rejected). Without it the
// full 64x32 address space is used unmodified.
module fb_rect_fill
  import fb_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic [COL_W-1:0]    X0,
  input  logic [ROW_W-1:0]    Y0,
  input  logic [COL_W-1:0]    X1,
  input  logic [ROW_W-1:0]    Y1,
  input  logic [COLOR_W-1:0]  COLOR,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR,
  output logic [ADDR_W-1:0]   WA,
  output logic [COLOR_W-1:0]  WD,
  output logic                WE
);

  fb_state_t          state;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   x0_q;
  logic [COL_W-1:0]   x1_q;
  logic [ROW_W-1:0]   y1_q;

  logic [COL_W-1:0]   x1_eff;
  logic [ROW_W-1:0]   y1_eff;
  logic               cmd_bad;

`ifdef FB_RECT_CLIP_EN
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(FB_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(FB_ROWS - 1);

  // Ordering check runs on the clamped end corner.
  always_comb begin
    x1_eff  = (X1 > COL_MAX) ? COL_MAX : X1;
    y1_eff  = (Y1 > ROW_MAX) ? ROW_MAX : Y1;
    cmd_bad = (X0 > COL_MAX) || (Y0 > ROW_MAX) || (X0 > x1_eff) || (Y0 > y1_eff);
  end
`else
  always_comb begin
    x1_eff  = X1;
    y1_eff  = Y1;
    cmd_bad = (X0 > X1) || (Y0 > Y1);
  end
`endif

  // WD doubles as the latched fill colour: it is loaded on acceptance and
  // held for the whole FILL phase.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      x0_q  <= '0;
      x1_q  <= '0;
      y1_q  <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      ERR   <= 1'b0;
      WE    <= 1'b0;
      WA    <= '0;
      WD    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (START) begin
            if (cmd_bad) begin
              state <= REJ;
              ERR   <= 1'b1;
            end else begin
              state <= FILL;
              col   <= X0;
              row   <= Y0;
              x0_q  <= X0;
              x1_q  <= x1_eff;
              y1_q  <= y1_eff;
              BUSY  <= 1'b1;
              WE    <= 1'b1;
              WA    <= {Y0, X0};
              WD    <= COLOR;
            end
          end
        end
        FILL: begin
          // WA is preloaded with the next pixel so each write is registered.
          if (col == x1_q) begin
            if (row == y1_q) begin
              state <= FIN;
              BUSY  <= 1'b0;
              WE    <= 1'b0;
              WA    <= '0;
              WD    <= '0;
              DONE  <= 1'b1;
            end else begin
              col <= x0_q;
              row <= row + 5'd1;
              WA  <= {row + 5'd1, x0_q};
            end
          end else begin
            col <= col + 6'd1;
            WA  <= {row, col + 6'd1};
          end
        end
        FIN: begin
          DONE  <= 1'b0;
          state <= IDLE;
        end
        REJ: begin
          ERR   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed self-checking bench for fb_rect_fill.
module tb_fb_rect_fill;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [5:0]  X0;
  logic [4:0]  Y0;
  logic [5:0]  X1;
  logic [4:0]  Y1;
  logic [7:0]  COLOR;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [10:0] WA;
  logic [7:0]  WD;
  logic        WE;

  int tests_run = 0;
  int tests_failed = 0;

  // Results of the most recent collect() run.
  logic [10:0] wa_q[$];
  int wd_bad;
  int busy_cnt;
  int first_we;
  int last_we;
  int done_idx;
  int err_idx;

  fb_rect_fill dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .X0    (X0),
    .Y0    (Y0),
    .X1    (X1),
    .Y1    (Y1),
    .COLOR (COLOR),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .ERR   (ERR),
    .WA    (WA),
    .WD    (WD),
    .WE    (WE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge while idle; returns at the negedge after the accepting edge.
  task automatic send(input logic [5:0] x0, input logic [4:0] y0,
                      input logic [5:0] x1, input logic [4:0] y1,
                      input logic [7:0] color);
    X0 = x0; Y0 = y0; X1 = x1; Y1 = y1; COLOR = color;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Samples one cycle per negedge until DONE or ERR is seen or the budget expires.
  task automatic collect(input int max_cycles, input logic [7:0] color);
    int i;
    wa_q.delete();
    wd_bad = 0; busy_cnt = 0; first_we = -1; last_we = -1;
    done_idx = -1; err_idx = -1;
    for (i = 0; i < max_cycles; i++) begin
      if (WE) begin
        wa_q.push_back(WA);
        if (WD !== color) wd_bad++;
        if (first_we < 0) first_we = i;
        last_we = i;
      end
      if (BUSY) busy_cnt++;
      if (DONE) done_idx = i;
      if (ERR) err_idx = i;
      if (DONE || ERR) break;
      @(negedge CLK);
    end
    if (i == max_cycles) check("timeout", 32'd1, 32'd0);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0;
    X0 = '0; Y0 = '0; X1 = '0; Y1 = '0; COLOR = '0;
    repeat (2) @(negedge CLK);
    check("rst_state", {BUSY, DONE, ERR, WE}, 32'h0);
    check("rst_wa", 32'(WA), 32'h0);
    check("rst_wd", 32'(WD), 32'h0);

    // First START on the first edge after reset release: (2,3)-(4,4).
    RST = 1'b0;
    send(6'd2, 5'd3, 6'd4, 5'd4, 8'hE0);
    collect(20, 8'hE0);
    check("f34_count", 32'(wa_q.size()), 32'd6);
    if (wa_q.size() == 6) begin
      check("f34_wa0", 32'(wa_q[0]), 32'h0C2);
      check("f34_wa1", 32'(wa_q[1]), 32'h0C3);
      check("f34_wa2", 32'(wa_q[2]), 32'h0C4);
      check("f34_wa3", 32'(wa_q[3]), 32'h102);
      check("f34_wa4", 32'(wa_q[4]), 32'h103);
      check("f34_wa5", 32'(wa_q[5]), 32'h104);
    end
    check("f34_first", 32'(first_we), 32'd0);
    check("f34_consec", 32'(last_we), 32'd5);
    check("f34_done", 32'(done_idx), 32'd6);
    check("f34_busy", 32'(busy_cnt), 32'd6);
    check("f34_wd", 32'(wd_bad), 32'd0);
    check("f34_fin_we", {31'd0, WE}, 32'd0);
    @(negedge CLK);
    check("f34_idle", {BUSY, DONE, ERR, WE}, 32'h0);

    // Rejected command: X0 > X1.
    send(6'd5, 5'd0, 6'd4, 5'd0, 8'h12);
    collect(10, 8'h12);
    check("rej_err", 32'(err_idx), 32'd0);
    check("rej_writes", 32'(wa_q.size()), 32'd0);
    check("rej_done", 32'(done_idx), 32'hFFFFFFFF);
    @(negedge CLK);
    check("rej_after", {BUSY, DONE, ERR, WE}, 32'h0);

    // Rejected command: Y0 > Y1.
    send(6'd0, 5'd9, 6'd3, 5'd8, 8'h12);
    collect(10, 8'h12);
    check("rejy_err", 32'(err_idx), 32'd0);
    check("rejy_writes", 32'(wa_q.size()), 32'd0);
    @(negedge CLK);

    // START re-pulsed during FILL with different coordinates is ignored.
    send(6'd1, 5'd1, 6'd2, 5'd2, 8'h1C);
    fork
      collect(20, 8'h1C);
      begin
        @(negedge CLK);
        X0 = 6'd10; Y0 = 5'd10; X1 = 6'd12; Y1 = 5'd12; COLOR = 8'hFF;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
      end
    join
    check("ign_count", 32'(wa_q.size()), 32'd4);
    if (wa_q.size() == 4) begin
      check("ign_wa0", 32'(wa_q[0]), 32'h041);
      check("ign_wa1", 32'(wa_q[1]), 32'h042);
      check("ign_wa2", 32'(wa_q[2]), 32'h081);
      check("ign_wa3", 32'(wa_q[3]), 32'h082);
    end
    check("ign_wd", 32'(wd_bad), 32'd0);
    check("ign_done", 32'(done_idx), 32'd4);
    @(negedge CLK);
    check("ign_idle", {BUSY, WE}, 32'h0);

    // Reset after the 3rd write of a 4x4 fill.
    send(6'd0, 5'd0, 6'd3, 5'd3, 8'h55);
    repeat (2) @(negedge CLK);
    check("rstmid_wa3", 32'(WA), 32'h002);
    @(posedge CLK);
    #1 RST = 1'b1;
    #1;
    check("rstmid_we", {31'd0, WE}, 32'd0);
    check("rstmid_bsy", {BUSY, DONE, ERR}, 32'h0);
    check("rstmid_wa", 32'(WA), 32'h0);
    @(negedge CLK);
    check("rstmid_done", {31'd0, DONE}, 32'd0);
    RST = 1'b0;
    send(6'd0, 5'd0, 6'd0, 5'd0, 8'h33);
    collect(10, 8'h33);
    check("px_count", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() == 1) check("px_wa", 32'(wa_q[0]), 32'h000);
    check("px_wd", 32'(wd_bad), 32'd0);
    check("px_done", 32'(done_idx), 32'd1);
    @(negedge CLK);

    // START held high: WE, DONE, IDLE repeating with a single-pixel command.
    begin
      int we_n, done_n, wa_bad;
      we_n = 0; done_n = 0; wa_bad = 0;
      X0 = 6'd5; Y0 = 5'd5; X1 = 6'd5; Y1 = 5'd5; COLOR = 8'hA5;
      START = 1'b1;
      for (int k = 0; k < 9; k++) begin
        @(negedge CLK);
        if (WE) begin
          we_n++;
          if (WA !== 11'h145) wa_bad++;
        end
        if (DONE) done_n++;
      end
      START = 1'b0;
      check("b2b_writes", 32'(we_n), 32'd3);
      check("b2b_done", 32'(done_n), 32'd3);
      check("b2b_wa", 32'(wa_bad), 32'd0);
      repeat (3) @(negedge CLK);
      check("b2b_idle", {BUSY, DONE, ERR, WE}, 32'h0);
    end

`ifdef FB_RECT_CLIP_EN
    send(6'd38, 5'd28, 6'd63, 5'd31, 8'h07);
    collect(20, 8'h07);
    check("clip_count", 32'(wa_q.size()), 32'd4);
    if (wa_q.size() == 4) begin
      check("clip_wa0", 32'(wa_q[0]), 32'h726);
      check("clip_wa1", 32'(wa_q[1]), 32'h727);
      check("clip_wa2", 32'(wa_q[2]), 32'h766);
      check("clip_wa3", 32'(wa_q[3]), 32'h767);
    end
    check("clip_done", 32'(done_idx), 32'd4);
    @(negedge CLK);
    send(6'd40, 5'd0, 6'd45, 5'd2, 8'h07);
    collect(10, 8'h07);
    check("clip_rej", 32'(err_idx), 32'd0);
    check("clip_rej_wr", 32'(wa_q.size()), 32'd0);
    @(negedge CLK);
`else
    // Full 64x32 fill covers every address once, in order.
    begin
      int order_bad;
      send(6'd0, 5'd0, 6'd63, 5'd31, 8'hFF);
      collect(2100, 8'hFF);
      order_bad = 0;
      for (int k = 0; k < wa_q.size(); k++)
        if (32'(wa_q[k]) != 32'(k)) order_bad++;
      check("full_count", 32'(wa_q.size()), 32'd2048);
      check("full_order", 32'(order_bad), 32'd0);
      check("full_wd", 32'(wd_bad), 32'd0);
      check("full_done", 32'(done_idx), 32'd2048);
      @(negedge CLK);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
